// File: rtl/r22sdf_twiddle_mult_if.sv
// Streaming sample bus for r22sdf_twiddle_mult: clock enable, complex input, complex output and
// start-of-frame marker.
interface r22sdf_twiddle_mult_if #(
  parameter int unsigned data_resolution = 16
);
  logic                              sys_en;
  logic signed [data_resolution-1:0] din_r;
  logic signed [data_resolution-1:0] din_i;
  logic signed [data_resolution-1:0] dout_r;
  logic signed [data_resolution-1:0] dout_i;
  logic                              dout_sof;

  modport master (
    output sys_en, din_r, din_i,
    input  dout_r, dout_i, dout_sof
  );

  modport slave (
    input  sys_en, din_r, din_i,
    output dout_r, dout_i, dout_sof
  );
endinterface

// File: rtl/r22sdf_twiddle_mult.sv
// R22SDF inter-stage twiddle multiplier: y = x * W_L^e, 3 enabled cycles of latency.
// Optional macro R22SDF_TW_BYPASS_EN: e==0 samples pass through bit-exact instead of x*0x7FFF.
module r22sdf_twiddle_mult #(
  parameter int unsigned data_resolution = 16,
  parameter int unsigned tw_resolution   = 16,
  parameter int unsigned seg_len         = 16,
  parameter int unsigned delay_tick      = 0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  r22sdf_twiddle_mult_if.slave  bus
);
  localparam int unsigned DW = data_resolution;
  localparam int unsigned TW = tw_resolution;
  localparam int unsigned KW = $clog2(seg_len);
  localparam int unsigned PW = DW + TW;
  localparam int unsigned SW = PW + 1;
  localparam logic [KW-1:0] KRst = KW'((seg_len - (delay_tick % seg_len)) % seg_len);
  localparam logic signed [SW-1:0] RndK = SW'(1) << (TW - 2);
  localparam logic signed [SW-1:0] MaxV = SW'((1 << (DW - 1)) - 1);
  localparam logic signed [SW-1:0] MinV = -MaxV - SW'(1);
  localparam longint TwoPiQ30 = 64'sd6746518851;

  // Fixed-point Q30 Taylor series, valid for |x| <= pi/2.
  function automatic longint taylor(input longint x, input bit is_sin);
    longint x2, term, sum, d;
    x2   = (x * x) >>> 30;
    term = is_sin ? x : (64'sd1 <<< 30);
    sum  = term;
    for (int n = 1; n < 12; n++) begin
      d    = is_sin ? longint'((2 * n) * (2 * n + 1)) : longint'((2 * n - 1) * (2 * n));
      term = -((term * x2) >>> 30) / d;
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic logic [2*TW-1:0] tw_entry(input int unsigned e);
    longint quarter, qd, x, c, s, cr, sr, scale, cq, sq;
    quarter = longint'(seg_len / 4);
    qd      = longint'(e) / quarter;
    x       = (TwoPiQ30 * (longint'(e) % quarter)) / longint'(seg_len);
    c       = taylor(x, 1'b0);
    s       = taylor(x, 1'b1);
    case (qd)
      0:       begin cr = c;  sr = s;  end
      1:       begin cr = -s; sr = c;  end
      2:       begin cr = -c; sr = -s; end
      default: begin cr = s;  sr = -c; end
    endcase
    scale = (64'sd1 <<< (TW - 1)) - 64'sd1;
    cq    = (cr * scale + (64'sd1 <<< 29)) >>> 30;
    sq    = (sr * scale + (64'sd1 <<< 29)) >>> 30;
    return {TW'(cq), TW'(-sq)};
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > MaxV) return DW'(MaxV);
    if (v < MinV) return DW'(MinV);
    return DW'(v);
  endfunction

  // Twiddle table {cos, -sin} of 2*pi*e/L, fixed at elaboration.
  logic [2*TW-1:0] w_rom [seg_len];
  for (genvar g = 0; g < seg_len; g++) begin : g_rom
    assign w_rom[g] = tw_entry(g);
  end

  logic [KW-1:0]          r_k;
  logic [1:0]             w_m;
  logic [KW-1:0]          w_e;
  logic [2*TW-1:0]        w_tw;
  logic signed [TW-1:0]   r_wr, r_wi;
  logic signed [DW-1:0]   r_ar1, r_ai1;
  logic                   r_sof1, r_sof2;
  logic signed [PW-1:0]   r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic signed [SW-1:0]   w_re_sh, w_im_sh;
  logic signed [DW-1:0]   w_nxt_r, w_nxt_i;
  logic signed [DW-1:0]   r_dout_r, r_dout_i;
  logic                   r_dout_sof;
`ifdef R22SDF_TW_BYPASS_EN
  logic                   r_byp1, r_byp2;
  logic signed [DW-1:0]   r_ar2, r_ai2;
`endif

  always_comb begin
    unique case (r_k[KW-1:KW-2])
      2'd0:    w_m = 2'd0;
      2'd1:    w_m = 2'd2;
      2'd2:    w_m = 2'd1;
      default: w_m = 2'd3;
    endcase
    w_e  = KW'({2'b00, r_k[KW-3:0]} * KW'(w_m));
    w_tw = w_rom[w_e];
  end

  always_comb begin
    w_re_sh = ((SW'(r_p_rr) - SW'(r_p_ii)) + RndK) >>> (TW - 1);
    w_im_sh = ((SW'(r_p_ri) + SW'(r_p_ir)) + RndK) >>> (TW - 1);
    w_nxt_r = sat(w_re_sh);
    w_nxt_i = sat(w_im_sh);
`ifdef R22SDF_TW_BYPASS_EN
    if (r_byp2) begin
      w_nxt_r = r_ar2;
      w_nxt_i = r_ai2;
    end
`endif
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_k        <= KRst;
      r_wr       <= '0;
      r_wi       <= '0;
      r_ar1      <= '0;
      r_ai1      <= '0;
      r_sof1     <= 1'b0;
      r_sof2     <= 1'b0;
      r_p_rr     <= '0;
      r_p_ii     <= '0;
      r_p_ri     <= '0;
      r_p_ir     <= '0;
      r_dout_r   <= '0;
      r_dout_i   <= '0;
      r_dout_sof <= 1'b0;
`ifdef R22SDF_TW_BYPASS_EN
      r_byp1     <= 1'b0;
      r_byp2     <= 1'b0;
      r_ar2      <= '0;
      r_ai2      <= '0;
`endif
    end else if (bus.sys_en) begin
      r_k        <= r_k + KW'(1);
      r_wr       <= w_tw[2*TW-1:TW];
      r_wi       <= w_tw[TW-1:0];
      r_ar1      <= bus.din_r;
      r_ai1      <= bus.din_i;
      r_sof1     <= (r_k == '0);
      r_sof2     <= r_sof1;
      r_p_rr     <= PW'(r_ar1) * PW'(r_wr);
      r_p_ii     <= PW'(r_ai1) * PW'(r_wi);
      r_p_ri     <= PW'(r_ar1) * PW'(r_wi);
      r_p_ir     <= PW'(r_ai1) * PW'(r_wr);
      r_dout_r   <= w_nxt_r;
      r_dout_i   <= w_nxt_i;
      r_dout_sof <= r_sof2;
`ifdef R22SDF_TW_BYPASS_EN
      r_byp1     <= (w_e == '0);
      r_byp2     <= r_byp1;
      r_ar2      <= r_ar1;
      r_ai2      <= r_ai1;
`endif
    end
  end

  assign bus.dout_r   = r_dout_r;
  assign bus.dout_i   = r_dout_i;
  assign bus.dout_sof = r_dout_sof;
endmodule
